pitch_zone_fsm: RTL and testbench

PITCH_ZONE_FSM -- requirements
Module: pitch_zone_fsm

---
 rtl/pitch_pkg.sv | 36 +++
 rtl/pitch_zone_fsm_classify.sv | 42 ++++
 rtl/pitch_zone_fsm.sv | 250 +++++++++++++++++++++++++
 tb/tb_pitch_zone_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// pitch_pkg: shared definitions for the pitch zone tracker.
//   - zone codes (VF, JF, T, JS, VS) used by the classifier and the FSM
//   - control FSM state encoding
//   - zone_onehot(): zone code -> one-hot zone vector (bit0 VF .. bit4 VS)
package pitch_pkg;

  localparam logic [2:0] ZONE_VF = 3'd0;
  localparam logic [2:0] ZONE_JF = 3'd1;
  localparam logic [2:0] ZONE_T  = 3'd2;
  localparam logic [2:0] ZONE_JS = 3'd3;
  localparam logic [2:0] ZONE_VS = 3'd4;

  localparam logic [3:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEARCH   = 2'd1,
    ST_CLASSIFY = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  // Unknown codes fall back to VF, the reset zone.
  function automatic logic [4:0] zone_onehot(input logic [2:0] code);
    logic [4:0] oh;
    case (code)
      ZONE_VF: oh = 5'b00001;
      ZONE_JF: oh = 5'b00010;
      ZONE_T:  oh = 5'b00100;
      ZONE_JS: oh = 5'b01000;
      ZONE_VS: oh = 5'b10000;
      default: oh = 5'b00001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pitch_zone_fsm_classify.sv
// zone_classify: combinational mapping of a signed (peak - target) difference
// onto a zone code.
//   diff        in  W+1  signed difference
//   tolerance   in  W    in-tune half-band (|diff| <= tolerance -> T)
//   very_thresh in  W    |diff| >= very_thresh -> VF/VS, otherwise JF/JS
//   zone_code   out 3    VF=0, JF=1, T=2, JS=3, VS=4
module zone_classify
  import pitch_pkg::*;
#(
  parameter int W = 10
) (
  input  logic signed [W:0]   diff,
  input  logic        [W-1:0] tolerance,
  input  logic        [W-1:0] very_thresh,
  output logic        [2:0]   zone_code
);

  logic [W:0] mag_s;
  logic       neg_s;

  // Magnitude of diff; W+1 bits always holds it since |diff| <= 2^W-1.
  always_comb begin
    neg_s = diff[W];
    if (neg_s) begin
      mag_s = ~diff + {{W{1'b0}}, 1'b1};
    end else begin
      mag_s = diff;
    end
  end

  // Threshold comparison; tolerance is checked first so it wins any overlap.
  always_comb begin
    if (mag_s <= {1'b0, tolerance}) begin
      zone_code = ZONE_T;
    end else if (mag_s >= {1'b0, very_thresh}) begin
      zone_code = neg_s ? ZONE_VF : ZONE_VS;
    end else begin
      zone_code = neg_s ? ZONE_JF : ZONE_JS;
    end
  end

endmodule

// File: rtl/pitch_zone_fsm.sv
// pitch_zone_fsm: picks a string target (nearest in auto mode, str_sel in
// manual mode), classifies the pitch error into one of five zones, debounces
// the zone and tracks a stable in-tune lock.
//   clk, reset_n           clock, async active-low reset
//   peak, peak_valid       dominant frequency and its one-cycle strobe
//   auto_mode, str_sel     target selection mode / manual string index
//   targets                packed table, string i at [i*W +: W]
//   tolerance, very_thresh classifier bands
//   zone, zone_code        committed zone (one-hot / encoded)
//   str_idx, diff          string and signed difference of the latest result
//   out_valid              one-cycle result strobe (COMMIT state)
//   locked                 committed zone T for LOCK_N consecutive results
//   overrun                sticky: a peak_valid arrived while busy
module pitch_zone_fsm
  import pitch_pkg::*;
#(
  parameter int W      = 10,
  parameter int NSTR   = 6,
  parameter int STABLE = 3,
  parameter int LOCK_N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W-1:0]         peak,
  input  logic                 peak_valid,
  input  logic                 auto_mode,
  input  logic [2:0]           str_sel,
  input  logic [NSTR*W-1:0]    targets,
  input  logic [W-1:0]         tolerance,
  input  logic [W-1:0]         very_thresh,
  output logic [4:0]           zone,
  output logic [2:0]           zone_code,
  output logic [2:0]           str_idx,
  output logic signed [W:0]    diff,
  output logic                 out_valid,
  output logic                 locked,
  output logic                 overrun
);

  localparam logic [2:0] LAST_IDX = 3'(NSTR - 1);
  localparam logic [3:0] STABLE_C = 4'(STABLE);
  localparam logic [3:0] LOCK_C   = 4'(LOCK_N);

  state_t            state_q, state_d;
  logic [W-1:0]      peak_q, peak_d;
  logic              auto_q, auto_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        idx_q, idx_d;
  logic signed [W:0] best_diff_q, best_diff_d;
  logic [W:0]        best_mag_q, best_mag_d;
  logic [2:0]        best_idx_q, best_idx_d;
  logic [2:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic [2:0]        zone_code_q, zone_code_d;
  logic [4:0]        zone_q, zone_d;
  logic [2:0]        str_idx_q, str_idx_d;
  logic signed [W:0] diff_q, diff_d;
  logic              out_valid_q, out_valid_d;
  logic              locked_q, locked_d;
  logic              overrun_q, overrun_d;

  logic              busy_s;
  logic [2:0]        sel_clamp_s;
  logic [2:0]        cur_idx_s;
  logic [W-1:0]      target_s;
  logic signed [W:0] cur_diff_s;
  logic [W:0]        cur_mag_s;
  logic [2:0]        class_s;

  assign busy_s = (state_q != ST_IDLE);

  // Clamp manual string index into the populated part of the table.
  always_comb begin
    if (str_sel > LAST_IDX) begin
      sel_clamp_s = LAST_IDX;
    end else begin
      sel_clamp_s = str_sel;
    end
  end

  // Target lookup for the string examined this SEARCH cycle (live read).
  always_comb begin
    cur_idx_s = auto_q ? idx_q : sel_q;
    target_s  = targets[W-1:0];
    for (int i = 0; i < NSTR; i++) begin
      if (cur_idx_s == 3'(i)) begin
        target_s = targets[i*W +: W];
      end else begin
        target_s = target_s;
      end
    end
  end

  // Widened signed difference so peak=0 against a large target cannot wrap.
  always_comb begin
    cur_diff_s = $signed({1'b0, peak_q}) - $signed({1'b0, target_s});
    if (cur_diff_s[W]) begin
      cur_mag_s = ~cur_diff_s + {{W{1'b0}}, 1'b1};
    end else begin
      cur_mag_s = cur_diff_s;
    end
  end

  zone_classify #(.W(W)) u_classify (
    .diff        (best_diff_q),
    .tolerance   (tolerance),
    .very_thresh (very_thresh),
    .zone_code   (class_s)
  );

  // Next-state logic: search, debounce, lock and result registers.
  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    auto_d      = auto_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    best_diff_d = best_diff_q;
    best_mag_d  = best_mag_q;
    best_idx_d  = best_idx_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    lock_cnt_d  = lock_cnt_q;
    zone_code_d = zone_code_q;
    zone_d      = zone_q;
    str_idx_d   = str_idx_q;
    diff_d      = diff_q;
    out_valid_d = 1'b0;
    locked_d    = locked_q;

    if (peak_valid && busy_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (peak_valid) begin
          peak_d  = peak;
          auto_d  = auto_mode;
          sel_d   = sel_clamp_s;
          idx_d   = 3'd0;
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        // Strict '<' keeps the lower index on a tie; idx 0 seeds the best.
        if ((idx_q == 3'd0) || (cur_mag_s < best_mag_q)) begin
          best_diff_d = cur_diff_s;
          best_mag_d  = cur_mag_s;
          best_idx_d  = cur_idx_s;
        end else begin
          best_diff_d = best_diff_q;
        end
        if (!auto_q || (idx_q == LAST_IDX)) begin
          state_d = ST_CLASSIFY;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_CLASSIFY: begin
        if (class_s == cand_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + 4'd1);
        end else begin
          cand_d = class_s;
          cnt_d  = 4'd1;
        end
        if (cnt_d >= STABLE_C) begin
          zone_code_d = cand_d;
        end else begin
          zone_code_d = zone_code_q;
        end
        zone_d = zone_onehot(zone_code_d);
        if (zone_code_d == ZONE_T) begin
          lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : (lock_cnt_q + 4'd1);
          locked_d   = (lock_cnt_d >= LOCK_C);
        end else begin
          lock_cnt_d = 4'd0;
          locked_d   = 1'b0;
        end
        str_idx_d   = best_idx_q;
        diff_d      = best_diff_q;
        out_valid_d = 1'b1;
        state_d     = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      peak_q      <= {W{1'b0}};
      auto_q      <= 1'b0;
      sel_q       <= 3'd0;
      idx_q       <= 3'd0;
      best_diff_q <= {(W+1){1'b0}};
      best_mag_q  <= {(W+1){1'b0}};
      best_idx_q  <= 3'd0;
      cand_q      <= ZONE_VF;
      cnt_q       <= 4'd0;
      lock_cnt_q  <= 4'd0;
      zone_code_q <= ZONE_VF;
      zone_q      <= 5'b00001;
      str_idx_q   <= 3'd0;
      diff_q      <= {(W+1){1'b0}};
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      auto_q      <= auto_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      best_diff_q <= best_diff_d;
      best_mag_q  <= best_mag_d;
      best_idx_q  <= best_idx_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      zone_code_q <= zone_code_d;
      zone_q      <= zone_d;
      str_idx_q   <= str_idx_d;
      diff_q      <= diff_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      overrun_q   <= overrun_d;
    end
  end

  assign zone      = zone_q;
  assign zone_code = zone_code_q;
  assign str_idx   = str_idx_q;
  assign diff      = diff_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pitch_zone_fsm.sv
// Directed bench for pitch_zone_fsm with default parameters.
module tb_pitch_zone_fsm;

  logic               clk;
  logic               reset_n;
  logic [9:0]         peak;
  logic               peak_valid;
  logic               auto_mode;
  logic [2:0]         str_sel;
  logic [59:0]        targets;
  logic [9:0]         tolerance;
  logic [9:0]         very_thresh;
  logic [4:0]         zone;
  logic [2:0]         zone_code;
  logic [2:0]         str_idx;
  logic signed [10:0] diff;
  logic               out_valid;
  logic               locked;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  pitch_zone_fsm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .peak        (peak),
    .peak_valid  (peak_valid),
    .auto_mode   (auto_mode),
    .str_sel     (str_sel),
    .targets     (targets),
    .tolerance   (tolerance),
    .very_thresh (very_thresh),
    .zone        (zone),
    .zone_code   (zone_code),
    .str_idx     (str_idx),
    .diff        (diff),
    .out_valid   (out_valid),
    .locked      (locked),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 11-bit two's complement pattern of a signed value, zero-extended.
  function automatic logic [31:0] d11(input int v);
    logic [10:0] t;
    t = v[10:0];
    return {21'd0, t};
  endfunction

  // Issue one pulse at the next negedge; return at the negedge where out_valid is due.
  task automatic pulse(input string tag, input logic [9:0] pk, input logic am,
                       input logic [2:0] ss, input int lat);
    @(negedge clk);
    peak       = pk;
    auto_mode  = am;
    str_sel    = ss;
    peak_valid = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      peak_valid = 1'b0;
      if (k == lat - 1) chk({tag, "_ov_early"}, {31'd0, out_valid}, 32'd0);
      if (k == lat)     chk({tag, "_ov"},       {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic result(input string tag, input logic [2:0] zc, input logic [2:0] si,
                        input int dv, input logic lk);
    logic [4:0] oh;
    oh = 5'b00001 << zc;
    chk({tag, "_zone"},   {27'd0, zone},      {27'd0, oh});
    chk({tag, "_code"},   {29'd0, zone_code}, {29'd0, zc});
    chk({tag, "_stridx"}, {29'd0, str_idx},   {29'd0, si});
    chk({tag, "_diff"},   {21'd0, diff},      d11(dv));
    chk({tag, "_locked"}, {31'd0, locked},    {31'd0, lk});
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_zone"},    {27'd0, zone},      32'd1);
    chk({tag, "_code"},    {29'd0, zone_code}, 32'd0);
    chk({tag, "_ov"},      {31'd0, out_valid}, 32'd0);
    chk({tag, "_locked"},  {31'd0, locked},    32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun},   32'd0);
    chk({tag, "_stridx"},  {29'd0, str_idx},   32'd0);
    chk({tag, "_diff"},    {21'd0, diff},      32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int hits;
    reset_n     = 1'b0;
    peak        = 10'd0;
    peak_valid  = 1'b0;
    auto_mode   = 1'b0;
    str_sel     = 3'd0;
    targets     = {10'd330, 10'd247, 10'd196, 10'd147, 10'd110, 10'd82};
    tolerance   = 10'd5;
    very_thresh = 10'd20;

    #12;
    reset_outputs("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_outputs("rst_idle");

    // Manual string 0, on pitch: zone T after three results, locked after six.
    pulse("m82_1", 10'd82, 1'b0, 3'd0, 3); result("m82_1", 3'd0, 3'd0, 0, 1'b0);
    pulse("m82_2", 10'd82, 1'b0, 3'd0, 3); result("m82_2", 3'd0, 3'd0, 0, 1'b0);
    pulse("m82_3", 10'd82, 1'b0, 3'd0, 3); result("m82_3", 3'd2, 3'd0, 0, 1'b0);
    pulse("m82_4", 10'd82, 1'b0, 3'd0, 3); result("m82_4", 3'd2, 3'd0, 0, 1'b0);
    pulse("m82_5", 10'd82, 1'b0, 3'd0, 3); result("m82_5", 3'd2, 3'd0, 0, 1'b0);
    pulse("m82_6", 10'd82, 1'b0, 3'd0, 3); result("m82_6", 3'd2, 3'd0, 0, 1'b1);
    chk("m82_ovl_low", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("m82_ov_single", {31'd0, out_valid}, 32'd0);

    // Very flat (diff -20 = very_thresh): lock holds until VF commits.
    pulse("m62_1", 10'd62, 1'b0, 3'd0, 3); result("m62_1", 3'd2, 3'd0, -20, 1'b1);
    pulse("m62_2", 10'd62, 1'b0, 3'd0, 3); result("m62_2", 3'd2, 3'd0, -20, 1'b1);
    pulse("m62_3", 10'd62, 1'b0, 3'd0, 3); result("m62_3", 3'd0, 3'd0, -20, 1'b0);

    // Boundaries on string 0: -5 -> T, -6 -> JF.
    pulse("m77_1", 10'd77, 1'b0, 3'd0, 3);
    pulse("m77_2", 10'd77, 1'b0, 3'd0, 3);
    pulse("m77_3", 10'd77, 1'b0, 3'd0, 3); result("m77_3", 3'd2, 3'd0, -5, 1'b0);
    pulse("m76_1", 10'd76, 1'b0, 3'd0, 3);
    pulse("m76_2", 10'd76, 1'b0, 3'd0, 3); result("m76_2", 3'd2, 3'd0, -6, 1'b0);
    pulse("m76_3", 10'd76, 1'b0, 3'd0, 3); result("m76_3", 3'd1, 3'd0, -6, 1'b0);

    // Widened difference and index clamp (7 -> 5).
    pulse("m0", 10'd0, 1'b0, 3'd0, 3);   result("m0", 3'd1, 3'd0, -82, 1'b0);
    pulse("clamp", 10'd335, 1'b0, 3'd7, 3); result("clamp", 3'd1, 3'd5, 5, 1'b0);

    // Auto mode, nearest is string 2 at +3.
    do_reset();
    pulse("a150_1", 10'd150, 1'b1, 3'd0, 8); result("a150_1", 3'd0, 3'd2, 3, 1'b0);
    pulse("a150_2", 10'd150, 1'b1, 3'd0, 8); result("a150_2", 3'd0, 3'd2, 3, 1'b0);
    pulse("a150_3", 10'd150, 1'b1, 3'd0, 8); result("a150_3", 3'd2, 3'd2, 3, 1'b0);

    // Auto mode tie (82/110 both 14 away): lower index, zone JS.
    do_reset();
    pulse("a96_1", 10'd96, 1'b1, 3'd0, 8); result("a96_1", 3'd0, 3'd0, 14, 1'b0);
    pulse("a96_2", 10'd96, 1'b1, 3'd0, 8);
    pulse("a96_3", 10'd96, 1'b1, 3'd0, 8); result("a96_3", 3'd3, 3'd0, 14, 1'b0);

    // Very sharp on string 5: 330+20.
    pulse("a350_1", 10'd350, 1'b1, 3'd0, 8);
    pulse("a350_2", 10'd350, 1'b1, 3'd0, 8);
    pulse("a350_3", 10'd350, 1'b1, 3'd0, 8); result("a350_3", 3'd4, 3'd5, 20, 1'b0);

    // Pulse during SEARCH is dropped and sets sticky overrun.
    do_reset();
    @(negedge clk);
    peak = 10'd150; auto_mode = 1'b1; peak_valid = 1'b1;
    @(negedge clk);
    peak_valid = 1'b0;
    @(negedge clk);
    peak = 10'd82; peak_valid = 1'b1;
    @(negedge clk);
    peak_valid = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    repeat (4) @(negedge clk);
    chk("ovr_ov_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("ovr_ov", {31'd0, out_valid}, 32'd1);
    result("ovr", 3'd0, 3'd2, 3, 1'b0);
    @(negedge clk);
    chk("ovr_no_second", {31'd0, out_valid}, 32'd0);
    pulse("ovr_next", 10'd82, 1'b0, 3'd0, 3);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of SEARCH aborts the result.
    @(negedge clk);
    peak = 10'd150; auto_mode = 1'b1; peak_valid = 1'b1;
    @(negedge clk);
    peak_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_outputs("abort_async");
    @(negedge clk);
    reset_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("abort_no_ov", hits, 32'd0);
    reset_outputs("abort_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
